// File: rtl/matmul_sequencer.sv
// Control sequencer for the 4x4 matrix multiplier: C = A x B, one MAC per cycle.
// Optional saturation of stored C elements is enabled with `define MATMUL_SATURATE_EN.
module matmul_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RES_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [3:0]            aindex,
  output logic [3:0]            bindex,
  input  logic [DATA_WIDTH-1:0] adata,
  input  logic [DATA_WIDTH-1:0] bdata,
  output logic                  resultwe,
  output logic [3:0]            resultindex,
  output logic [RES_WIDTH-1:0]  resultdata
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                 state;
  logic [1:0]             i, j, k;
  logic [ACC_WIDTH-1:0]   acc;
  logic [PROD_WIDTH-1:0]  prod;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [RES_WIDTH-1:0]   res_val;
  logic [1:0]             k_inc, j_inc, i_inc;

  assign prod    = adata * bdata;
  assign acc_sum = acc + ACC_WIDTH'(prod);
  assign k_inc   = 2'(k + 2'd1);
  assign j_inc   = 2'(j + 2'd1);
  assign i_inc   = 2'(i + 2'd1);
  assign busy    = (state != IDLE);

`ifdef MATMUL_SATURATE_EN
  logic sum_big;
  logic acc_big;

  // Anything above RES_WIDTH bits cannot be represented and clamps to all ones.
  if (ACC_WIDTH > RES_WIDTH) begin : g_sat
    assign sum_big = |acc_sum[ACC_WIDTH-1:RES_WIDTH];
    assign acc_big = |acc[ACC_WIDTH-1:RES_WIDTH];
  end else begin : g_nosat
    assign sum_big = 1'b0;
    assign acc_big = 1'b0;
  end

  assign res_val = sum_big ? {RES_WIDTH{1'b1}} : RES_WIDTH'(acc_sum);

  // Sticky overflow: raised at the end of any saturating WRITE, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      overflow <= 1'b0;
    end else if (state == WRITE && acc_big) begin
      overflow <= 1'b1;
    end
  end
`else
  assign res_val  = RES_WIDTH'(acc_sum);
  assign overflow = 1'b0;
`endif

  // Result value is captured on the edge entering WRITE, equal to the registered acc during WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      i           <= 2'd0;
      j           <= 2'd0;
      k           <= 2'd0;
      acc         <= '0;
      done        <= 1'b0;
      aindex      <= 4'd0;
      bindex      <= 4'd0;
      resultwe    <= 1'b0;
      resultindex <= 4'd0;
      resultdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          resultwe <= 1'b0;
          aindex   <= 4'd0;
          bindex   <= 4'd0;
          if (start) begin
            state <= MAC;
            i     <= 2'd0;
            j     <= 2'd0;
            k     <= 2'd0;
            acc   <= '0;
            done  <= 1'b0;
          end
        end

        MAC: begin
          acc <= acc_sum;
          if (k == 2'd3) begin
            state       <= WRITE;
            k           <= 2'd0;
            aindex      <= 4'd0;
            bindex      <= 4'd0;
            resultwe    <= 1'b1;
            resultindex <= {i, j};
            resultdata  <= res_val;
          end else begin
            k      <= k_inc;
            aindex <= {i, k_inc};
            bindex <= {k_inc, j};
          end
        end

        WRITE: begin
          resultwe <= 1'b0;
          acc      <= '0;
          j        <= j_inc;
          if (j == 2'd3) begin
            i <= i_inc;
          end
          if (i == 2'd3 && j == 2'd3) begin
            state  <= IDLE;
            done   <= 1'b1;
            aindex <= 4'd0;
            bindex <= 4'd0;
          end else begin
            state  <= MAC;
            aindex <= (j == 2'd3) ? {i_inc, 2'd0} : {i, 2'd0};
            bindex <= {2'd0, j_inc};
          end
        end

        default: begin
          state    <= IDLE;
          resultwe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed, table-driven bench for matmul_sequencer with a behavioural A/B register bank.
module tb_matmul_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, overflow, resultwe;
  logic [3:0]    aindex, bindex, resultindex;
  logic [DW-1:0] adata, bdata;
  logic [RW-1:0] resultdata;

  logic [DW-1:0] a_mem [16];
  logic [DW-1:0] b_mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign adata = a_mem[aindex];
  assign bdata = b_mem[bindex];

  matmul_sequencer #(.DATA_WIDTH(DW), .RES_WIDTH(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .aindex      (aindex),
    .bindex      (bindex),
    .adata       (adata),
    .bdata       (bdata),
    .resultwe    (resultwe),
    .resultindex (resultindex),
    .resultdata  (resultdata)
  );

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit            ident;   // A = identity, else A filled with aval
    logic [DW-1:0] aval;
    bit            seq;     // B[n] = n+1, else B filled with bval
    logic [DW-1:0] bval;
    logic [RW-1:0] dconst;  // expected C element when not seq
    bit            ovf;     // expected Overflow at end of run
    int            glitch;  // cycle at which a stray start pulse is driven (0 = none)
    bit            hold;    // keep start high past the end of the run
  } vec_t;

  vec_t vecs [6];

  task automatic load(input vec_t v);
    for (int n = 0; n < 16; n++) begin
      a_mem[n] = v.ident ? ((n % 5 == 0) ? DW'(1) : DW'(0)) : v.aval;
      b_mem[n] = v.seq ? DW'(n + 1) : v.bval;
    end
  endtask

  task automatic chk_zero(input string tag, input int cyc);
    chk({tag, "_busy"}, cyc, 64'(busy), 64'd0);
    chk({tag, "_done"}, cyc, 64'(done), 64'd0);
    chk({tag, "_ovf"},  cyc, 64'(overflow), 64'd0);
    chk({tag, "_we"},   cyc, 64'(resultwe), 64'd0);
    chk({tag, "_aidx"}, cyc, 64'(aindex), 64'd0);
    chk({tag, "_bidx"}, cyc, 64'(bindex), 64'd0);
    chk({tag, "_ridx"}, cyc, 64'(resultindex), 64'd0);
    chk({tag, "_rdat"}, cyc, 64'(resultdata), 64'd0);
  endtask

  // Start is sampled at edge E0; cycle c is the interval after edge E(c-1).
  task automatic run(input vec_t v, input int stop_at);
    int nwe;
    nwe = 0;
    load(v);
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 81; cyc++) begin
      int e, ph;
      @(negedge clk);
      if (cyc == stop_at) begin
        start = 1'b0;
        return;
      end
      e  = (cyc - 1) / 5;
      ph = (cyc - 1) % 5;
      chk("busy", cyc, 64'(busy), 64'(cyc <= 80));
      chk("we", cyc, 64'(resultwe), 64'(cyc <= 80 && ph == 4));
      if (cyc <= 80 && ph < 4) begin
        chk("aidx", cyc, 64'(aindex), 64'((e / 4) * 4 + ph));
        chk("bidx", cyc, 64'(bindex), 64'(ph * 4 + e % 4));
      end
      if (resultwe) begin
        nwe++;
        chk("ridx", cyc, 64'(resultindex), 64'(e));
        chk("rdat", cyc, 64'(resultdata), v.seq ? 64'(e + 1) : 64'(v.dconst));
      end
      if (cyc == 1) begin
        chk("done_clr", cyc, 64'(done), 64'd0);
        chk("ovf_clr", cyc, 64'(overflow), 64'd0);
      end
      if (cyc == 81) begin
        chk("done_set", cyc, 64'(done), 64'd1);
        chk("ovf_end", cyc, 64'(overflow), 64'(v.ovf));
        chk("aidx_idle", cyc, 64'(aindex), 64'd0);
        chk("nwe", cyc, 64'(nwe), 64'd16);
      end
      start = v.hold || (cyc == v.glitch);
    end
    if (v.hold) begin
      @(negedge clk);
      chk("retrig_busy", 82, 64'(busy), 64'd1);
      chk("retrig_done", 82, 64'(done), 64'd0);
      start = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{ident: 1'b1, aval: 16'h0, seq: 1'b1, bval: 16'h0, dconst: 32'h0, ovf: 1'b0, glitch: 0, hold: 1'b0};
    vecs[1] = '{ident: 1'b0, aval: 16'h2, seq: 1'b0, bval: 16'h3, dconst: 32'd24, ovf: 1'b0, glitch: 0, hold: 1'b0};
`ifdef MATMUL_SATURATE_EN
    vecs[2] = '{ident: 1'b0, aval: 16'hFFFF, seq: 1'b0, bval: 16'hFFFF, dconst: 32'hFFFF_FFFF, ovf: 1'b1, glitch: 0, hold: 1'b0};
`else
    vecs[2] = '{ident: 1'b0, aval: 16'hFFFF, seq: 1'b0, bval: 16'hFFFF, dconst: 32'hFFF8_0004, ovf: 1'b0, glitch: 0, hold: 1'b0};
`endif
    vecs[3] = '{ident: 1'b1, aval: 16'h0, seq: 1'b1, bval: 16'h0, dconst: 32'h0, ovf: 1'b0, glitch: 30, hold: 1'b0};
    vecs[4] = '{ident: 1'b1, aval: 16'h0, seq: 1'b1, bval: 16'h0, dconst: 32'h0, ovf: 1'b0, glitch: 0, hold: 1'b0};
    vecs[5] = '{ident: 1'b0, aval: 16'h2, seq: 1'b0, bval: 16'h3, dconst: 32'd24, ovf: 1'b0, glitch: 0, hold: 1'b1};

    load(vecs[0]);
    #1;
    chk_zero("rst", 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 0, 64'(busy), 64'd0);
    chk("idle_we", 0, 64'(resultwe), 64'd0);

    for (int t = 0; t < 6; t++) begin
      run(vecs[t], 0);
    end

    // Reset in the middle of a run, then a clean run afterwards.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[0], 42);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst", 42);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("postrst_we", c, 64'(resultwe), 64'd0);
      chk("postrst_busy", c, 64'(busy), 64'd0);
    end
    run(vecs[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
